runway_arbiter: RTL
===================

Name: runway_arbiter

Overview:
- Shares the single runway between queued landing and takeoff requests, and issues one grant at a time.
- Weather gating comes from the ECSU state code: 00 all-clear, 01 caution, 10 high-risk, 11 emergency.
- Sits between the aircraft request interface and the tower display/indicator logic, downstream of the weather control unit.
- Two internal FIFOs, a grant FSM, a runway-occupancy timer and a landing-streak fairness counter.

Parameters:
- DEPTH, 4, entries per request FIFO (power of two, ≥2).
- ID_W, 4, aircraft ID width.
- OCC_CYCLES, 8, runway occupancy per grant in all-clear (≥2).
- MAX_LAND_STREAK, 3, consecutive landings allowed while a takeoff waits (≥1).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous active-high reset.
- ECSU_state  in  2  weather state: 00 all-clear, 01 caution, 10 high-risk, 11 emergency.
- landing_req  in  1  one-cycle push of landing_id into landing FIFO.
- landing_id  in  ID_W  aircraft requesting landing.
- takeoff_req  in  1  one-cycle push of takeoff_id into takeoff FIFO.
- takeoff_id  in  ID_W  aircraft requesting takeoff.
- grant_valid  out  1  one-cycle pulse, grant issued.
- grant_is_landing  out  1  qualifies grant_valid (1 = landing).
- grant_id  out  ID_W  granted aircraft; holds until next grant.
- runway_busy  out  1  runway occupied.
- landing_count  out  clog2(DEPTH)+1  landing FIFO occupancy.
- takeoff_count  out  clog2(DEPTH)+1  takeoff FIFO occupancy.
- landing_full, takeoff_full  out  1 each  FIFO at DEPTH.
- req_dropped  out  1  one-cycle pulse, a request hit a full FIFO.

Behaviour:
- Clock, reset and output registration:
  - One clock, CLK. RST is synchronous and active-high.
  - On reset, all outputs are 0, both FIFOs are empty, FSM = IDLE, timer = 0, streak = 0.
  - Reset mid-occupancy aborts the current occupancy and discards all queued requests.
- All outputs are registered.
- FIFO push:
  - A request sampled at edge k appears in its count after edge k.
  - A push to a full FIFO is ignored: contents and count are unchanged, and req_dropped = 1 for the cycle after edge k.
  - Simultaneous landing and takeoff pushes are both accepted. req_dropped is the OR of the two drop conditions.
  - A push and a pop on the same FIFO at the same edge leave the count unchanged. Pointers wrap modulo DEPTH.
- FSM states: IDLE and OCCUPIED.
- IDLE, eligibility check at each edge:
  - landing eligible = landing FIFO non-empty.
  - takeoff eligible = takeoff FIFO non-empty AND ECSU_state in {00, 01}.
  - A pushed entry is visible one edge after its push. Earliest grant is therefore edge k+1 for a request at edge k into an empty FIFO.
- Selection when both are eligible:
  - Landing wins, unless streak ≥ MAX_LAND_STREAK; then takeoff wins.
- Grant actions at the grant edge:
  - Pop the winning FIFO.
  - grant_valid = 1 for exactly one cycle; grant_is_landing and grant_id are set.
  - runway_busy = 1; FSM → OCCUPIED.
  - Timer = occ − 1, where occ = OCC_CYCLES if ECSU_state == 00, else 2·OCC_CYCLES.
  - Timer width: clog2(2·OCC_CYCLES).
- Streak counter update at the grant edge:
  - Landing granted while the takeoff FIFO is non-empty: streak +1, saturating.
  - Landing granted with the takeoff FIFO empty: streak = 0.
  - Takeoff granted: streak = 0.
- OCCUPIED:
  - If timer == 0: FSM → IDLE and runway_busy = 0. Otherwise timer −1.
  - runway_busy is high for exactly occ cycles.
  - At least one IDLE cycle separates consecutive grants.
  - ECSU_state changes during OCCUPIED do not alter the running timer. The new state applies at the next grant.
- High-risk/emergency (10/11):
  - Takeoffs remain queued and are not granted; they keep accepting pushes until full.
  - Streak is not evaluated for takeoff selection.
  - Takeoff grants resume when the state returns to 00/01.
- No eligible request in IDLE: stay in IDLE, outputs idle.

Decomposition:
- Shared package: ECSU state encodings (ST_ALL_CLEAR=2'b00, ST_CAUTION=2'b01, ST_HIGH_RISK=2'b10, ST_EMERGENCY=2'b11) and FSM state encodings. The package is shared with the weather control unit.
- One sub-module: req_fifo (parameterised DEPTH/ID_W, push/pop/full/empty/count), instantiated twice.
- FSM, timer and streak counter stay in runway_arbiter.

Test Plan:
- Reset, then one landing: ECSU_state=00, landing_req with id=5 at edge 1 → grant_valid=1, grant_is_landing=1, grant_id=5 after edge 2. runway_busy is high for 8 cycles, then low. landing_count returns to 0.
- Caution doubles occupancy: ECSU_state=01, one takeoff with id=3 → takeoff granted; runway_busy is high for 16 cycles.
- Fairness: state 00, 5 landings (ids 1–5) after 4 landings (1–4) have been pushed (DEPTH=4 → landing id 5 dropped with req_dropped pulse), plus 1 takeoff id=9 → grant order 1, 2, 3, 9, 4.
- Weather block: state 10 with takeoffs 7, 8 queued → no grant. Landing 2 pushed → only 2 is granted. Switch to 00 → 7 then 8 are granted.
- Full/simultaneous: with the takeoff FIFO full, a takeoff_req and a landing_req arrive in the same cycle → landing accepted, takeoff dropped, req_dropped=1 for one cycle, takeoff_count stays 4.
- Mid-operation reset: RST asserted during OCCUPIED with 3 entries queued → next cycle runway_busy=0, both counts 0, no grant follows.

Source files
------------

// File: rtl/runway_arbiter_pkg.sv
// Shared encodings for the runway arbiter and the weather control unit.
// Holds the ECSU weather codes, the grant FSM states and the takeoff weather gate.
package runway_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_ALL_CLEAR = 2'b00,
    ST_CAUTION   = 2'b01,
    ST_HIGH_RISK = 2'b10,
    ST_EMERGENCY = 2'b11
  } ecsu_state_e;

  typedef enum logic {
    FSM_IDLE     = 1'b0,
    FSM_OCCUPIED = 1'b1
  } arb_state_e;

  // Takeoffs are only released in all-clear or caution weather.
  function automatic logic takeoff_allowed(input logic [1:0] ecsu);
    return (ecsu_state_e'(ecsu) == ST_ALL_CLEAR) || (ecsu_state_e'(ecsu) == ST_CAUTION);
  endfunction

endpackage

// File: rtl/runway_arbiter_req_fifo.sv
// Request queue for one direction (landing or takeoff) of runway traffic.
// Pushes to a full queue are discarded and flagged on drop.
module req_fifo #(
  parameter  int DEPTH = 4,
  parameter  int ID_W  = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic [ID_W-1:0]  push_id,
  input  logic             pop,
  output logic [ID_W-1:0]  pop_id,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  logic [ID_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             accept;
  logic             do_pop;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    accept   = push && !full_q;
    do_pop   = pop && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (accept) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d  = count_q + CNT_W'(accept) - CNT_W'(do_pop);
    full_d   = (count_d == CNT_W'(DEPTH));
    empty_d  = (count_d == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge CLK) begin
    if (accept) mem[wr_ptr_q] <= push_id;
  end

  assign pop_id = mem[rd_ptr_q];
  assign count  = count_q;
  assign full   = full_q;
  assign empty  = empty_q;
  assign drop   = push && full_q;

endmodule

// File: rtl/runway_arbiter.sv
// Single-runway arbiter: queues landing/takeoff requests and issues one grant at a time,
// gated by ECSU weather state, with a landing-streak limit to keep takeoffs moving.
module runway_arbiter
  import runway_arbiter_pkg::*;
#(
  parameter  int DEPTH           = 4,
  parameter  int ID_W            = 4,
  parameter  int OCC_CYCLES      = 8,
  parameter  int MAX_LAND_STREAK = 3,
  localparam int CNT_W           = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       ECSU_state,
  input  logic             landing_req,
  input  logic [ID_W-1:0]  landing_id,
  input  logic             takeoff_req,
  input  logic [ID_W-1:0]  takeoff_id,
  output logic             grant_valid,
  output logic             grant_is_landing,
  output logic [ID_W-1:0]  grant_id,
  output logic             runway_busy,
  output logic [CNT_W-1:0] landing_count,
  output logic [CNT_W-1:0] takeoff_count,
  output logic             landing_full,
  output logic             takeoff_full,
  output logic             req_dropped
);

  localparam int TIMER_W  = $clog2(2 * OCC_CYCLES);
  localparam int STREAK_W = $clog2(MAX_LAND_STREAK + 1);

  localparam logic [TIMER_W-1:0]  OCC_CLEAR  = TIMER_W'(OCC_CYCLES - 1);
  localparam logic [TIMER_W-1:0]  OCC_SLOW   = TIMER_W'(2 * OCC_CYCLES - 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LAND_STREAK);

  logic [ID_W-1:0] land_head, to_head;
  logic            land_empty, to_empty;
  logic            land_drop, to_drop;
  logic            pop_land, pop_to;

  req_fifo #(.DEPTH(DEPTH), .ID_W(ID_W)) u_land_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .push    (landing_req),
    .push_id (landing_id),
    .pop     (pop_land),
    .pop_id  (land_head),
    .count   (landing_count),
    .full    (landing_full),
    .empty   (land_empty),
    .drop    (land_drop)
  );

  req_fifo #(.DEPTH(DEPTH), .ID_W(ID_W)) u_takeoff_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .push    (takeoff_req),
    .push_id (takeoff_id),
    .pop     (pop_to),
    .pop_id  (to_head),
    .count   (takeoff_count),
    .full    (takeoff_full),
    .empty   (to_empty),
    .drop    (to_drop)
  );

  arb_state_e          state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                grant_valid_q, grant_valid_d;
  logic                grant_is_landing_q, grant_is_landing_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic                runway_busy_q, runway_busy_d;
  logic                req_dropped_q, req_dropped_d;

  logic                land_elig, to_elig, pick_takeoff;
  logic [TIMER_W-1:0]  occ_load;

  always_comb begin
    land_elig    = !land_empty;
    to_elig      = !to_empty && takeoff_allowed(ECSU_state);
    // Landings have priority until the streak limit is reached with a takeoff waiting.
    pick_takeoff = to_elig && (!land_elig || (streak_q >= STREAK_MAX));
    occ_load     = (ecsu_state_e'(ECSU_state) == ST_ALL_CLEAR) ? OCC_CLEAR : OCC_SLOW;

    state_d            = state_q;
    timer_d            = timer_q;
    streak_d           = streak_q;
    grant_valid_d      = 1'b0;
    grant_is_landing_d = grant_is_landing_q;
    grant_id_d         = grant_id_q;
    runway_busy_d      = runway_busy_q;
    req_dropped_d      = land_drop | to_drop;
    pop_land           = 1'b0;
    pop_to             = 1'b0;

    unique case (state_q)
      FSM_IDLE: begin
        if (land_elig || to_elig) begin
          grant_valid_d = 1'b1;
          runway_busy_d = 1'b1;
          state_d       = FSM_OCCUPIED;
          timer_d       = occ_load;
          if (pick_takeoff) begin
            pop_to             = 1'b1;
            grant_is_landing_d = 1'b0;
            grant_id_d         = to_head;
            streak_d           = '0;
          end else begin
            pop_land           = 1'b1;
            grant_is_landing_d = 1'b1;
            grant_id_d         = land_head;
            // A takeoff waiting (even weather-blocked) extends the streak.
            if (to_empty)                streak_d = '0;
            else if (streak_q != STREAK_MAX) streak_d = streak_q + STREAK_W'(1);
          end
        end
      end
      FSM_OCCUPIED: begin
        if (timer_q == '0) begin
          state_d       = FSM_IDLE;
          runway_busy_d = 1'b0;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      default: state_d = FSM_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q            <= FSM_IDLE;
      timer_q            <= '0;
      streak_q           <= '0;
      grant_valid_q      <= 1'b0;
      grant_is_landing_q <= 1'b0;
      grant_id_q         <= '0;
      runway_busy_q      <= 1'b0;
      req_dropped_q      <= 1'b0;
    end else begin
      state_q            <= state_d;
      timer_q            <= timer_d;
      streak_q           <= streak_d;
      grant_valid_q      <= grant_valid_d;
      grant_is_landing_q <= grant_is_landing_d;
      grant_id_q         <= grant_id_d;
      runway_busy_q      <= runway_busy_d;
      req_dropped_q      <= req_dropped_d;
    end
  end

  assign grant_valid      = grant_valid_q;
  assign grant_is_landing = grant_is_landing_q;
  assign grant_id         = grant_id_q;
  assign runway_busy      = runway_busy_q;
  assign req_dropped      = req_dropped_q;

endmodule
